// File: rtl/ddr_fetch_pkg.sv
// Shared defaults, FSM encoding and base-address helper for the DDR line prefetch engine.
package ddr_fetch_pkg;

    localparam int DEF_WORDS_PER_LINE  = 320;
    localparam int DEF_FIFO_DEPTH      = 64;
    localparam int DEF_MAX_OUTSTANDING = 4;
    localparam int DEF_ADDR_W          = 22;
    localparam int DEF_LINE_W          = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    // Word address of the first word of a frame-buffer line.
    function automatic logic [31:0] line_base(input logic [31:0] line_sel, input logic [31:0] wpl);
        return line_sel * wpl;
    endfunction

endpackage

// File: rtl/ddr_fetch_fifo.sv
// First-word fall-through FIFO with synchronous flush and occupancy output.
module ddr_fetch_fifo
    import ddr_fetch_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       not_empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   LVL_ONE = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   level_r;
    logic             rd_fire_s;

    assign rd_fire_s = rd_en && not_empty;
    assign not_empty = (level_r != {(PTR_W + 1){1'b0}});
    assign rd_data   = mem_r[rd_ptr_r];
    assign level     = level_r;

    // storage array, written on every accepted push
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // pointers and occupancy; a flush empties the queue in one cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (wr_en) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en, rd_fire_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/ddr_line_fetch.sv
// Scanline prefetch engine: credit-limited DDR read issue feeding a FWFT pixel FIFO.
// Build option DDR_FETCH_DOUBLE_SCAN_EN fetches frame-buffer line lineNum>>1 (line doubling).
module ddr_line_fetch
    import ddr_fetch_pkg::*;
#(
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int LINE_W          = DEF_LINE_W
) (
    input  logic                          clk133_p,
    input  logic                          rst,
    input  logic                          lineStart,
    input  logic [LINE_W-1:0]             lineNum,
    output logic                          reqValid,
    output logic [ADDR_W-1:0]             reqAddr,
    input  logic                          reqReady,
    input  logic                          readValid,
    input  logic [31:0]                   readData,
    output logic                          pixValid,
    output logic [31:0]                   pixData,
    input  logic                          pixPop,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
    output logic                          underflow,
    output logic                          lineDone
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int IDX_W = $clog2(WORDS_PER_LINE + 1);
    localparam int SUM_W = LVL_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
    localparam logic [OUT_W-1:0] OUT_ONE   = OUT_W'(1);
    localparam logic [OUT_W-1:0] OUT_ZERO  = OUT_W'(0);
    localparam logic [OUT_W-1:0] OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_ZERO  = LVL_W'(0);
    localparam logic [SUM_W-1:0] SUM_DEPTH = SUM_W'(FIFO_DEPTH);

    fetch_state_t      state_r, state_nxt_s;
    logic [IDX_W-1:0]  word_idx_r, word_idx_nxt_s;
    logic [IDX_W-1:0]  rx_idx_r, rx_idx_nxt_s;
    logic [OUT_W-1:0]  outstanding_r, outstanding_nxt_s;
    logic [OUT_W-1:0]  discard_r, discard_nxt_s;
    logic [ADDR_W-1:0] base_r, base_nxt_s, line_base_s;
    logic [ADDR_W-1:0] req_addr_r, req_addr_nxt_s;
    logic              req_valid_r, req_valid_nxt_s;
    logic              underflow_r, underflow_nxt_s;
    logic              line_done_r, line_done_nxt_s;
    logic [LVL_W-1:0]  level_nxt_s;
    logic [LINE_W-1:0] line_sel_s;
    logic              hs_s, rv_s, drop_s, wr_en_s, rd_en_s, credit_ok_s, pix_valid_s;

`ifdef DDR_FETCH_DOUBLE_SCAN_EN
    assign line_sel_s = {1'b0, lineNum[LINE_W-1:1]};
`else
    assign line_sel_s = lineNum;
`endif
    assign line_base_s = ADDR_W'(line_base(32'(line_sel_s), 32'(WORDS_PER_LINE)));

    // A beat with nothing outstanding is ignored so the counters can never wrap below zero.
    assign hs_s    = req_valid_r && reqReady;
    assign rv_s    = readValid && (outstanding_r != OUT_ZERO);
    assign drop_s  = rv_s && (discard_r != OUT_ZERO);
    assign wr_en_s = rv_s && !drop_s && !lineStart;
    assign rd_en_s = pixPop && pix_valid_s && !lineStart;

    // next values of counters, FIFO level and the credit decision derived from them
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        if (hs_s && !rv_s) begin
            outstanding_nxt_s = outstanding_r + OUT_ONE;
        end else if (!hs_s && rv_s) begin
            outstanding_nxt_s = outstanding_r - OUT_ONE;
        end else begin
            outstanding_nxt_s = outstanding_r;
        end

        // on restart every beat still in flight belongs to the abandoned line
        discard_nxt_s = discard_r;
        if (lineStart) begin
            discard_nxt_s = outstanding_nxt_s;
        end else if (drop_s) begin
            discard_nxt_s = discard_r - OUT_ONE;
        end else begin
            discard_nxt_s = discard_r;
        end

        level_nxt_s = fifoLevel;
        if (lineStart) begin
            level_nxt_s = LVL_ZERO;
        end else if (wr_en_s && !rd_en_s) begin
            level_nxt_s = fifoLevel + LVL_ONE;
        end else if (!wr_en_s && rd_en_s) begin
            level_nxt_s = fifoLevel - LVL_ONE;
        end else begin
            level_nxt_s = fifoLevel;
        end

        credit_ok_s = (({1'b0, level_nxt_s} + SUM_W'(outstanding_nxt_s)) < SUM_DEPTH)
                      && (outstanding_nxt_s < OUT_MAX);

        word_idx_nxt_s = word_idx_r;
        base_nxt_s     = base_r;
        rx_idx_nxt_s   = rx_idx_r;
        if (lineStart) begin
            word_idx_nxt_s = IDX_ZERO;
            base_nxt_s     = line_base_s;
            rx_idx_nxt_s   = IDX_ZERO;
        end else begin
            word_idx_nxt_s = hs_s ? (word_idx_r + IDX_ONE) : word_idx_r;
            base_nxt_s     = base_r;
            rx_idx_nxt_s   = wr_en_s ? (rx_idx_r + IDX_ONE) : rx_idx_r;
        end

        underflow_nxt_s = underflow_r || (pixPop && !pix_valid_s);
    end

    // FSM next state; credit only shrinks on a handshake, so a held request stays legal
    always_comb begin
        state_nxt_s = state_r;
        if (lineStart) begin
            state_nxt_s = credit_ok_s ? ST_ISSUE : ST_STALL;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_IDLE;
                ST_ISSUE: begin
                    if (hs_s && (word_idx_r == LAST_IDX)) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = credit_ok_s ? ST_ISSUE : ST_STALL;
                    end
                end
                ST_STALL: state_nxt_s = credit_ok_s ? ST_ISSUE : ST_STALL;
                ST_DRAIN: state_nxt_s = (outstanding_r == OUT_ZERO) ? ST_IDLE : ST_DRAIN;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs, computed one cycle ahead and registered
    always_comb begin
        req_valid_nxt_s = (state_nxt_s == ST_ISSUE);
        if (req_valid_nxt_s) begin
            req_addr_nxt_s = base_nxt_s + ADDR_W'(word_idx_nxt_s);
        end else begin
            req_addr_nxt_s = req_addr_r;
        end
        line_done_nxt_s = wr_en_s && (rx_idx_r == LAST_IDX);
    end

    // FSM state register
    always_ff @(posedge clk133_p) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // counters and registered outputs
    always_ff @(posedge clk133_p) begin
        if (rst) begin
            word_idx_r    <= IDX_ZERO;
            rx_idx_r      <= IDX_ZERO;
            outstanding_r <= OUT_ZERO;
            discard_r     <= OUT_ZERO;
            base_r        <= {ADDR_W{1'b0}};
            req_addr_r    <= {ADDR_W{1'b0}};
            req_valid_r   <= 1'b0;
            underflow_r   <= 1'b0;
            line_done_r   <= 1'b0;
        end else begin
            word_idx_r    <= word_idx_nxt_s;
            rx_idx_r      <= rx_idx_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            discard_r     <= discard_nxt_s;
            base_r        <= base_nxt_s;
            req_addr_r    <= req_addr_nxt_s;
            req_valid_r   <= req_valid_nxt_s;
            underflow_r   <= underflow_nxt_s;
            line_done_r   <= line_done_nxt_s;
        end
    end

    ddr_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk133_p),
        .rst       (rst),
        .flush     (lineStart),
        .wr_en     (wr_en_s),
        .wr_data   (readData),
        .rd_en     (rd_en_s),
        .rd_data   (pixData),
        .not_empty (pix_valid_s),
        .level     (fifoLevel)
    );

    assign pixValid  = pix_valid_s;
    assign reqValid  = req_valid_r;
    assign reqAddr   = req_addr_r;
    assign underflow = underflow_r;
    assign lineDone  = line_done_r;

endmodule

// File: tb/tb_ddr_line_fetch.sv
// Scoreboard bench for ddr_line_fetch: DDR return model, request/pixel monitors, directed line scenarios.
module tb_ddr_line_fetch;

    localparam int WPL = 320;
`ifdef DDR_FETCH_DOUBLE_SCAN_EN
    localparam int BASE6 = 960;
    localparam int BASE7 = 960;
`else
    localparam int BASE6 = 1920;
    localparam int BASE7 = 2240;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lineStart = 1'b0;
    logic [9:0]  lineNum = 10'd0;
    logic        reqValid;
    logic [21:0] reqAddr;
    logic        reqReady = 1'b0;
    logic        readValid;
    logic [31:0] readData;
    logic        pixValid;
    logic [31:0] pixData;
    logic        pixPop = 1'b0;
    logic [6:0]  fifoLevel;
    logic        underflow;
    logic        lineDone;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int pop_cnt = 0;
    int done_cnt = 0;
    int model_cyc = 0;
    bit pix_auto = 1'b0;

    logic [21:0] req_exp[$];
    logic [31:0] pix_exp[$];
    int          pend_due[$];
    logic [21:0] pend_addr[$];

    ddr_line_fetch dut (
        .clk133_p  (clk),
        .rst       (rst),
        .lineStart (lineStart),
        .lineNum   (lineNum),
        .reqValid  (reqValid),
        .reqAddr   (reqAddr),
        .reqReady  (reqReady),
        .readValid (readValid),
        .readData  (readData),
        .pixValid  (pixValid),
        .pixData   (pixData),
        .pixPop    (pixPop),
        .fifoLevel (fifoLevel),
        .underflow (underflow),
        .lineDone  (lineDone)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_data(input logic [21:0] a);
        return {10'h2A5, a};
    endfunction

    function automatic int exp_base(input int line);
`ifdef DDR_FETCH_DOUBLE_SCAN_EN
        return (line / 2) * WPL;
`else
        return line * WPL;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pix_auto) pixPop = pixValid;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lineStart = 1'b0;
        reqReady = 1'b0;
        pix_auto = 1'b0;
        pixPop = 1'b0;
        repeat (3) step();
        req_exp.delete();
        pix_exp.delete();
        rst = 1'b0;
    endtask

    task automatic start_line(input int line);
        lineNum = 10'(line);
        lineStart = 1'b1;
        step();
        lineStart = 1'b0;
        req_exp.delete();
        pix_exp.delete();
        for (int i = 0; i < WPL; i++) begin
            logic [21:0] a;
            a = 22'(exp_base(line) + i);
            req_exp.push_back(a);
            pix_exp.push_back(mk_data(a));
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((req_exp.size() != 0 || pix_exp.size() != 0 || pend_due.size() != 0 ||
                fifoLevel != 7'd0 || reqValid) && n < budget) begin
            step();
            n++;
        end
        check({name, "_done_in_budget"}, 32'(n < budget), 32'd1);
        repeat (3) step();
    endtask

    // DDR controller model: fixed 2-cycle read latency, in-order returns, cleared by reset
    initial begin
        readValid = 1'b0;
        readData = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_due.delete();
                pend_addr.delete();
            end else if (reqValid && reqReady) begin
                pend_due.push_back(model_cyc + 2);
                pend_addr.push_back(reqAddr);
            end
            @(posedge clk);
            #1;
            model_cyc++;
            readValid = 1'b0;
            if (!rst && pend_due.size() != 0 && pend_due[0] <= model_cyc) begin
                readValid = 1'b1;
                readData = mk_data(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
        end
    end

    // monitor: compare every handshake address and every popped word against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (reqValid && reqReady) begin
                    hs_cnt++;
                    if (req_exp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL req_extra got=%0d exp=none", reqAddr);
                    end else begin
                        check("req_addr", 32'(reqAddr), 32'(req_exp.pop_front()));
                    end
                end
                if (pixPop && pixValid) begin
                    pop_cnt++;
                    if (pix_exp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pix_extra got=%0h exp=none", pixData);
                    end else begin
                        check("pix_data", pixData, pix_exp.pop_front());
                    end
                end
                if (lineDone) done_cnt++;
            end
        end
    end

    initial begin
        int hs0, pop0, done0, hs_abort, n;

        do_reset();
        check("rst_reqValid", 32'(reqValid), 32'd0);
        check("rst_reqAddr", 32'(reqAddr), 32'd0);
        check("rst_pixValid", 32'(pixValid), 32'd0);
        check("rst_fifoLevel", 32'(fifoLevel), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_lineDone", 32'(lineDone), 32'd0);

        // full line 3 with continuous popping
        hs0 = hs_cnt; pop0 = pop_cnt; done0 = done_cnt;
        reqReady = 1'b1;
        pix_auto = 1'b1;
        start_line(3);
        wait_idle("line3", 3000);
        check("line3_handshakes", 32'(hs_cnt - hs0), 32'd320);
        check("line3_pops", 32'(pop_cnt - pop0), 32'd320);
        check("line3_lineDone", 32'(done_cnt - done0), 32'd1);
        check("line3_underflow", 32'(underflow), 32'd0);

        // no popping: issue must stop once the FIFO plus in-flight reach depth
        hs0 = hs_cnt; done0 = done_cnt;
        pix_auto = 1'b0;
        pixPop = 1'b0;
        start_line(4);
        n = 0;
        while (fifoLevel != 7'd64 && n < 1000) begin
            step();
            n++;
        end
        repeat (10) step();
        check("stall_level", 32'(fifoLevel), 32'd64);
        check("stall_handshakes", 32'(hs_cnt - hs0), 32'd64);
        check("stall_reqValid", 32'(reqValid), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            pixPop = 1'b1;
            step();
            pixPop = 1'b0;
            repeat (10) step();
            check("pop_release", 32'(hs_cnt - hs0), 32'(64 + k));
            check("pop_refill", 32'(fifoLevel), 32'd64);
        end
        pix_auto = 1'b1;
        wait_idle("line4", 3000);
        check("line4_lineDone", 32'(done_cnt - done0), 32'd1);

        // controller back-pressure: request must be held steady
        hs0 = hs_cnt;
        reqReady = 1'b0;
        start_line(2);
        for (int k = 0; k < 10; k++) begin
            check("hold_reqValid", 32'(reqValid), 32'd1);
            check("hold_reqAddr", 32'(reqAddr), 32'd640);
            step();
        end
        check("hold_no_hs", 32'(hs_cnt - hs0), 32'd0);
        reqReady = 1'b1;
        step();
        reqReady = 1'b0;
        repeat (5) step();
        check("hold_one_hs", 32'(hs_cnt - hs0), 32'd1);
        check("hold_next_addr", 32'(reqAddr), 32'd641);
        reqReady = 1'b1;
        wait_idle("line2", 3000);

        // abort line 5 mid-flight and restart on line 6
        hs0 = hs_cnt; done0 = done_cnt;
        pix_auto = 1'b0;
        pixPop = 1'b0;
        start_line(5);
        n = 0;
        while ((hs_cnt - hs0) < 8 && n < 200) begin
            step();
            n++;
        end
        check("abort_reached_8", 32'(n < 200), 32'd1);
        start_line(6);
        hs_abort = hs_cnt - hs0;
        check("abort_flush", 32'(fifoLevel), 32'd0);
        pix_auto = 1'b1;
        wait_idle("line6", 3000);
        check("abort_new_hs", 32'(hs_cnt - hs0 - hs_abort), 32'd320);
        check("abort_lineDone", 32'(done_cnt - done0), 32'd1);

        // base address of lines 6 and 7
        reqReady = 1'b0;
        start_line(6);
        check("base6_valid", 32'(reqValid), 32'd1);
        check("base6_addr", 32'(reqAddr), 32'(BASE6));
        start_line(7);
        check("base7_addr", 32'(reqAddr), 32'(BASE7));
        reqReady = 1'b1;
        wait_idle("line7", 3000);

        // underflow is sticky across later valid pops
        pix_auto = 1'b0;
        pixPop = 1'b1;
        step();
        pixPop = 1'b0;
        step();
        check("underflow_set", 32'(underflow), 32'd1);
        check("underflow_level", 32'(fifoLevel), 32'd0);
        pix_auto = 1'b1;
        start_line(1);
        wait_idle("line1", 3000);
        check("underflow_sticky", 32'(underflow), 32'd1);

        // reset in the middle of a line
        start_line(8);
        repeat (20) step();
        do_reset();
        check("midrst_reqValid", 32'(reqValid), 32'd0);
        check("midrst_fifoLevel", 32'(fifoLevel), 32'd0);
        check("midrst_underflow", 32'(underflow), 32'd0);
        hs0 = hs_cnt;
        reqReady = 1'b1;
        pix_auto = 1'b1;
        start_line(9);
        wait_idle("line9", 3000);
        check("line9_handshakes", 32'(hs_cnt - hs0), 32'd320);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr_line_fetch.md
Name: ddr_line_fetch

Overview:
- Line-prefetch engine directly upstream of the DDR controller, in the 133 MHz controller clock domain.
- On each scanline start, issues burst-of-2 read requests (one 32-bit word each) for that line's frame-buffer words.
- Collects the 32-bit read data into a credit-managed FIFO.
- The pixel side pops the FIFO; crossing to the 25 MHz domain happens downstream of this block.

Parameters:
- WORDS_PER_LINE, 320, 32-bit words fetched per line (640 px x 16 bpp).
- FIFO_DEPTH, 64, prefetch FIFO entries (power of 2).
- MAX_OUTSTANDING, 4, read requests in flight, not yet returned.
- ADDR_W, 22, word-address width presented to the controller.
- LINE_W, 10, line-number width.

Ports:
- clk133_p in 1: controller clock, sole clock.
- rst in 1: synchronous, active-high reset.
- lineStart in 1: one-cycle pulse to begin fetching line lineNum.
- lineNum in LINE_W: line index, sampled when lineStart=1.
- reqValid out 1: read request valid.
- reqAddr out ADDR_W: word address of the request.
- reqReady in 1: controller accepts the request (handshake when reqValid && reqReady).
- readValid in 1: one cycle per returned 32-bit word, in request order.
- readData in 32: returned word.
- pixValid out 1: FIFO not empty.
- pixData out 32: FIFO head word (first-word fall-through).
- pixPop in 1: consume the head word.
- fifoLevel out 7: FIFO occupancy.
- underflow out 1: sticky; pixPop seen while pixValid=0.
- lineDone out 1: pulse when the last word of the line enters the FIFO.

Behaviour:
- Interface: one clock (clk133_p); reset is synchronous and active-high (rst).
- Reset values:
  - reqValid=0, reqAddr=0, pixValid=0, fifoLevel=0, underflow=0, lineDone=0.
  - FSM=IDLE; all counters 0.
- Base address: base = lineNum*WORDS_PER_LINE, computed at lineStart, truncated to ADDR_W. Each request's reqAddr = base + wordIdx.
- Credit rule: a request may be presented only if fifoLevel + outstanding < FIFO_DEPTH and outstanding < MAX_OUTSTANDING.
  - outstanding increments on handshake and decrements on readValid.
  - Simultaneous handshake and readValid leave outstanding unchanged.
- FSM:
  - IDLE -> ISSUE on lineStart.
  - ISSUE: reqValid=1 while the credit rule holds. reqValid/reqAddr are held stable until reqReady. On handshake wordIdx++. Credit exhausted -> STALL.
  - STALL: reqValid=0; return to ISSUE when credit frees.
  - After the WORDS_PER_LINE-th handshake -> DRAIN.
  - DRAIN: wait for outstanding=0 -> IDLE.
  - lineDone pulses on the readValid carrying word WORDS_PER_LINE-1.
- lineStart in a state other than IDLE (abort/restart):
  - Flush the FIFO (fifoLevel=0 next cycle).
  - Load the new base; wordIdx=0.
  - Set discard = outstanding. The next `discard` readValid beats are dropped, not written, and decrement outstanding.
  - Issue for the new line proceeds under the normal credit rule.
  - A lineStart in the same cycle as a handshake counts that request as outstanding for discard.
- FIFO: write on readValid (if not discarding); read on pixPop && pixValid.
  - Simultaneous write and read keep the level.
  - Write to a full FIFO is impossible by the credit rule.
  - pixPop while empty: no state change, underflow<=1 and it stays set until rst.
- rst mid-line: everything returns to reset values. The controller is reset in the same cycle, so no discard is needed.

Optional Feature:
- DDR_FETCH_DOUBLE_SCAN_EN defined: base uses lineNum>>1, so each frame-buffer line is fetched twice for a 320x240-line buffer on the 480-line display. WORDS_PER_LINE is unchanged.
- Not defined: base uses lineNum directly.

Decomposition:
- Package ddr_fetch_pkg: defaults for WORDS_PER_LINE, FIFO_DEPTH, MAX_OUTSTANDING, ADDR_W; FSM state encoding (IDLE, ISSUE, STALL, DRAIN).
- Sub-module ddr_fetch_fifo: synchronous first-word fall-through FIFO with flush input and level output.
- FSM, credit and discard logic stay in the top module.

Test Plan:
- Reset, then lineStart with lineNum=3, reqReady=1, data returned 2 cycles after each handshake, pixPop=1 whenever pixValid -> requests at 960..1279 in order; exactly 320 words out in order; lineDone once; underflow=0.
- pixPop=0 throughout -> issue stalls with fifoLevel+outstanding=64; fifoLevel reaches 64; no request beyond word 63 until a pop; each pop releases exactly one request.
- reqReady held 0 for 10 cycles on the first request -> reqValid=1 and reqAddr constant throughout; exactly one handshake when reqReady rises.
- Abort: lineStart(line 5) after 8 handshakes with 3 outstanding, then lineStart(line 6) -> those 3 returns dropped; FIFO holds only words from base 1920 onward; outstanding never negative.
- pixPop with empty FIFO -> underflow=1 and stays 1 across later successful pops; clears only on rst.
- DDR_FETCH_DOUBLE_SCAN_EN: lines 6 and 7 -> both start at address 960. Without the macro -> 1920 and 2240.
